// File: rtl/acq_pkg.sv
// Shared state encoding and default sizing for the acquisition sequencer.
package acq_pkg;

  localparam int DEF_NCH   = 8;
  localparam int DEF_DW    = 16;
  localparam int DEF_CNT_W = 32;
  localparam int CH_W      = $clog2(DEF_NCH);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/acq_chan_sel.sv
// Lowest-set-bit picker over the remaining-channel mask of the current frame.
// Latency: purely combinational.
// Backpressure: none; the caller clears the picked bit when its beat is accepted.
module acq_chan_sel
  import acq_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CW  = CH_W
) (
  input  logic [NCH-1:0] rem,
  output logic [CW-1:0]  idx,
  output logic [NCH-1:0] sel,
  output logic           one_left
);

  // Scan from the top so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rem[i]) idx = CW'(i);
    end
  end

  assign sel      = rem & (~rem + NCH'(1));
  assign one_left = (rem != '0) && ((rem & (rem - NCH'(1))) == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Trigger-started acquisition run: captures data_number frames and serialises enabled channels.
// Latency: adc_valid to first m_valid is one cycle; one beat per cycle while m_ready is held.
// Backpressure: m_ready low holds the beat stable; frames arriving while a frame is emitting are dropped and flagged.
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        data_number,
  input  logic [NCH-1:0]          channel_ctrl,
  input  logic                    trigger_cmd,
  input  logic                    adc_valid,
  input  logic [NCH*DW-1:0]       adc_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DW-1:0]           m_data,
  output logic [$clog2(NCH)-1:0]  m_chan,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int CW = $clog2(NCH);

  state_t           state;
  state_t           state_nx;
  logic             trig_d;
  logic             start;
  logic [CNT_W-1:0] n_lat;
  logic [NCH-1:0]   mask_lat;
  logic [NCH-1:0]   rem;
  logic [NCH-1:0]   sel;
  logic [CW-1:0]    sel_idx;
  logic             one_left;
  logic [DW-1:0]    samples [NCH];
  logic             fire;
  logic             frame_end;
  logic             final_frame;
  logic             accept;
  logic             drop;

  acq_chan_sel #(
    .NCH (NCH),
    .CW  (CW)
  ) u_chan_sel (
    .rem      (rem),
    .idx      (sel_idx),
    .sel      (sel),
    .one_left (one_left)
  );

  assign start       = trigger_cmd & ~trig_d;
  assign fire        = (state == EMIT) & m_ready;
  assign frame_end   = fire & one_left;
  assign final_frame = (frame_cnt == n_lat);
  // A new frame is taken either while waiting, or in the very cycle the buffer drains mid-run.
  assign accept      = adc_valid & ((state == CAPTURE) | (frame_end & ~final_frame));
  assign drop        = adc_valid & (state == EMIT) & ~accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ARM;
      ARM:     state_nx = (data_number == '0 || channel_ctrl == '0) ? DONE : CAPTURE;
      CAPTURE: if (adc_valid) state_nx = EMIT;
      EMIT: begin
        if (frame_end) begin
          if (final_frame)    state_nx = DONE;
          else if (adc_valid) state_nx = EMIT;
          else                state_nx = CAPTURE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_valid = (state == EMIT);
    busy    = (state != IDLE);
    done    = (state == DONE);
    m_chan  = m_valid ? sel_idx : '0;
    m_data  = m_valid ? samples[sel_idx] : '0;
    m_last  = m_valid & one_left & final_frame;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_d    <= 1'b0;
      n_lat     <= '0;
      mask_lat  <= '0;
      rem       <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) samples[i] <= '0;
    end else begin
      trig_d <= trigger_cmd;
      if (state == IDLE && start) begin
        frame_cnt <= '0;
        overrun   <= 1'b0;
      end
      // Config is sampled once per run; later register writes only affect the next run.
      if (state == ARM) begin
        n_lat    <= data_number;
        mask_lat <= channel_ctrl;
      end
      if (accept) begin
        for (int i = 0; i < NCH; i++) samples[i] <= adc_data[i*DW +: DW];
        rem       <= mask_lat;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (fire) begin
        rem <= rem & ~sel;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomised bench for acq_sequencer: a behavioural run model feeds an expected-beat queue
// that an independent monitor drains on every accepted output beat.
module tb_acq_sequencer;

  localparam int NCH   = 8;
  localparam int DW    = 16;
  localparam int CNT_W = 32;
  localparam int CW    = 3;

  localparam int MS_IDLE = 0;
  localparam int MS_CFG  = 1;
  localparam int MS_RUN  = 2;
  localparam int MS_FIN  = 3;

  logic              clk;
  logic              rst;
  logic [CNT_W-1:0]  data_number;
  logic [NCH-1:0]    channel_ctrl;
  logic              trigger_cmd;
  logic              adc_valid;
  logic [NCH*DW-1:0] adc_data;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_data;
  logic [CW-1:0]     m_chan;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              overrun;
  logic [CNT_W-1:0]  frame_cnt;

  typedef struct {
    logic [DW-1:0] d;
    int            ch;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    xfers  = 0;

  acq_sequencer #(
    .NCH   (NCH),
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_number  (data_number),
    .channel_ctrl (channel_ctrl),
    .trigger_cmd  (trigger_cmd),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_chan       (m_chan),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: run-level bookkeeping of frames and outstanding beats, one step per clock.
  int               mst = MS_IDLE;
  bit               trig_prev = 1'b0;
  int               beats_left = 0;
  logic [CNT_W-1:0] mdl_cnt = '0;
  logic [CNT_W-1:0] mdl_n = '0;
  logic [NCH-1:0]   mdl_mask = '0;
  bit               mdl_ovr = 1'b0;
  bit               frame_ends;
  bit               free;
  bit               finishing;
  int               top_ch;
  beat_t            b;

  always @(negedge clk) begin
    if (rst) begin
      mst        = MS_IDLE;
      trig_prev  = 1'b0;
      beats_left = 0;
      mdl_cnt    = '0;
      mdl_ovr    = 1'b0;
      exp_q.delete();
    end else begin
      chk("busy", busy, mst != MS_IDLE);
      chk("done", done, mst == MS_FIN);
      chk("m_valid", m_valid, (mst == MS_RUN) && (beats_left > 0));
      chk("frame_cnt", frame_cnt, mdl_cnt);
      chk("overrun", overrun, mdl_ovr);
      case (mst)
        MS_IDLE: begin
          if (trigger_cmd && !trig_prev) begin
            mst     = MS_CFG;
            mdl_cnt = '0;
            mdl_ovr = 1'b0;
          end
        end
        MS_CFG: begin
          mdl_n      = data_number;
          mdl_mask   = channel_ctrl;
          beats_left = 0;
          mst        = (mdl_n == 0 || mdl_mask == 0) ? MS_FIN : MS_RUN;
        end
        MS_RUN: begin
          frame_ends = (beats_left == 1) && m_ready;
          free       = (beats_left == 0) || frame_ends;
          finishing  = frame_ends && (mdl_cnt == mdl_n);
          if (beats_left > 0 && m_ready) beats_left--;
          if (adc_valid) begin
            if (free && !finishing) begin
              mdl_cnt++;
              top_ch = 0;
              for (int ch = 0; ch < NCH; ch++) if (mdl_mask[ch]) top_ch = ch;
              for (int ch = 0; ch < NCH; ch++) begin
                if (mdl_mask[ch]) begin
                  b.d    = adc_data[ch*DW +: DW];
                  b.ch   = ch;
                  b.last = (ch == top_ch) && (mdl_cnt == mdl_n);
                  exp_q.push_back(b);
                end
              end
              beats_left = $countones(mdl_mask);
            end else begin
              mdl_ovr = 1'b1;
            end
          end
          if (finishing) mst = MS_FIN;
        end
        default: mst = MS_IDLE;
      endcase
      trig_prev = trigger_cmd;
    end
  end

  // Monitor: compares every accepted beat and checks stall stability.
  bit            stalled = 1'b0;
  logic [DW-1:0] prev_d;
  logic [CW-1:0] prev_c;
  logic          prev_l;
  beat_t         e;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_hold", {m_valid, m_data, m_chan, m_last}, {1'b1, prev_d, prev_c, prev_l});
      end
      if (m_valid && m_ready) begin
        chk("queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", {m_data, m_chan, m_last}, {e.d, e.ch[CW-1:0], e.last});
        end
        xfers++;
      end
      stalled = m_valid && !m_ready;
      prev_d  = m_data;
      prev_c  = m_chan;
      prev_l  = m_last;
    end
  end

  task automatic run(input int n, input logic [NCH-1:0] mask, input int gap, input int pulses,
                     input int ready_pct, input int stall_c, input bit retrig, input int rst_c,
                     input int exp_ovr);
    int x0, busy_cyc, done_cyc, sent, c;
    bit aborted;
    x0 = xfers; busy_cyc = 0; done_cyc = 0; sent = 0; aborted = 0;
    data_number  = n;
    channel_ctrl = mask;
    trigger_cmd  = 1'b1;
    tick();
    busy_cyc += int'(busy);
    done_cyc += int'(done);
    for (c = 0; c <= 3000; c++) begin
      trigger_cmd = retrig && (c >= 2) && (c < 4);
      if (retrig && c == 3) data_number = 99;
      adc_valid = 1'b0;
      if (c >= 1 && ((c - 1) % gap) == 0 && (pulses == 0 || sent < pulses)) begin
        adc_valid = 1'b1;
        adc_data  = {$urandom, $urandom, $urandom, $urandom};
        sent++;
      end
      m_ready = (stall_c >= 0 && c >= stall_c && c < stall_c + 5) ? 1'b0
                : ($urandom_range(0, 99) < ready_pct);
      if (c == rst_c) begin
        rst = 1'b1; trigger_cmd = 1'b0; adc_valid = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data_chan", {m_data, m_chan}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        aborted = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        break;
      end
      tick();
      busy_cyc += int'(busy);
      done_cyc += int'(done);
      if (!busy) break;
    end
    adc_valid   = 1'b0;
    trigger_cmd = 1'b0;
    m_ready     = 1'b1;
    if (!aborted) begin
      chk("run_end_busy", busy, 0);
      chk("queue_drained", exp_q.size(), 0);
      chk("beat_count", xfers - x0, (n == 0 || mask == 0) ? 0 : n * $countones(mask));
      chk("frame_cnt_end", frame_cnt, (mask == 0) ? 0 : n);
      chk("done_width", done_cyc, 1);
      if (exp_ovr >= 0) chk("overrun_end", overrun, exp_ovr);
      if (n == 0 || mask == 0) chk("busy_len", busy_cyc, 2);
    end
    tick();
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    data_number  = '0;
    channel_ctrl = '0;
    trigger_cmd  = 1'b0;
    adc_valid    = 1'b0;
    adc_data     = '0;
    m_ready      = 1'b1;
    #2;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_outputs", {m_data, m_chan, m_last, busy, done, overrun}, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // n, mask, gap, pulses, ready%, stall_c, retrig, rst_c, exp_ovr
    run(3, 8'h85, 10, 3, 100, -1, 1'b0, -1, 0);
    run(2, 8'hFF, 20, 2, 100,  4, 1'b0, -1, 0);
    run(4, 8'hFF,  4, 0, 100, -1, 1'b0, -1, 1);
    run(0, 8'hFF,  2, 0, 100, -1, 1'b0, -1, 0);
    run(3, 8'h00,  2, 0, 100, -1, 1'b0, -1, 0);
    run(5, 8'h01,  1, 5, 100, -1, 1'b1, -1, 0);
    run(3, 8'hFF, 12, 0, 100, -1, 1'b0,  5, -1);
    run(2, 8'h5A,  9, 2, 100, -1, 1'b0, -1, 0);
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(1, 5), NCH'($urandom_range(1, 255)), $urandom_range(1, 10), 0,
          $urandom_range(40, 100), -1, 1'b0, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
